pc_next_unit: RTL and testbench

Program-counter and redirect stage that consumes the one-bit `branch` decision from the branch comparator and produces the fetch address for the 16-bit datapath. It holds the PC register and increments it every cycle. On a taken branch or jump it redirects to the computed target and raises a multi-cycle flush for the younger, wrong-path instructions. It also supports fetch stalls and a terminal halt state.

---
 rtl/pc_next_unit.sv | 112 +++++++++++
 tb/tb_pc_next_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/pc_next_unit.sv
// rtl/pc_next_unit.sv - program counter with branch/jump redirect, timed flush, stall and halt
module pc_next_unit #(
    parameter int ADDR_WIDTH   = 16,
    parameter int OFFSET_WIDTH = 8,
    parameter int RESET_PC     = 0,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    branch,
    input  logic                    branch_valid,
    input  logic [ADDR_WIDTH-1:0]   branch_pc,
    input  logic [OFFSET_WIDTH-1:0] branch_offset,
    input  logic                    jump,
    input  logic [ADDR_WIDTH-1:0]   jump_target,
    input  logic                    stall,
    input  logic                    halt,
    output logic [ADDR_WIDTH-1:0]   pc,
    output logic                    pc_valid,
    output logic                    flush,
    output logic                    halted
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FLUSH = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic                    pc_valid_q, pc_valid_d;
    logic                    flush_q, flush_d;
    logic [3:0]              flush_cnt_q, flush_cnt_d;

    logic [ADDR_WIDTH-1:0]   offset_ext;
    logic [ADDR_WIDTH-1:0]   branch_target;
    logic                    taken;
    logic                    redirect_ok;

    assign offset_ext    = {{(ADDR_WIDTH-OFFSET_WIDTH){branch_offset[OFFSET_WIDTH-1]}}, branch_offset};
    assign branch_target = branch_pc + ADDR_WIDTH'(1) + offset_ext;
    assign taken         = branch_valid & branch;
    // The last flush cycle already accepts a new redirect, so back-to-back
    // redirects are spaced exactly FLUSH_CYCLES edges apart.
    assign redirect_ok   = (state_q == S_RUN) ||
                           ((state_q == S_FLUSH) && (flush_cnt_q == 4'd1));

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pc_valid_d  = pc_valid_q;
        flush_d     = 1'b0;
        flush_cnt_d = flush_cnt_q;

        case (state_q)
            S_HALT: begin
                pc_valid_d = 1'b0;
            end
            default: begin
                pc_valid_d = 1'b1;
                if (halt) begin
                    state_d     = S_HALT;
                    pc_valid_d  = 1'b0;
                    flush_cnt_d = 4'd0;
                end else if (redirect_ok && taken) begin
                    state_d     = S_FLUSH;
                    pc_d        = branch_target;
                    flush_d     = 1'b1;
                    flush_cnt_d = 4'(FLUSH_CYCLES);
                end else if (redirect_ok && jump) begin
                    state_d     = S_FLUSH;
                    pc_d        = jump_target;
                    flush_d     = 1'b1;
                    flush_cnt_d = 4'(FLUSH_CYCLES);
                end else begin
                    pc_d = stall ? pc_q : pc_q + ADDR_WIDTH'(1);
                    if (state_q == S_FLUSH) begin
                        flush_cnt_d = flush_cnt_q - 4'd1;
                        if (flush_cnt_q == 4'd1) begin
                            state_d = S_RUN;
                        end else begin
                            flush_d = 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_RUN;
            pc_q        <= ADDR_WIDTH'(RESET_PC);
            pc_valid_q  <= 1'b0;
            flush_q     <= 1'b0;
            flush_cnt_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pc_valid_q  <= pc_valid_d;
            flush_q     <= flush_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign pc       = pc_q;
    assign pc_valid = pc_valid_q;
    assign flush    = flush_q;
    assign halted   = (state_q == S_HALT);

endmodule

// File: tb/tb_pc_next_unit.sv
// tb/tb_pc_next_unit.sv - directed scoreboard bench for pc_next_unit
module tb_pc_next_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch, branch_valid, jump, stall, halt;
    logic [15:0] branch_pc, jump_target;
    logic [7:0]  branch_offset;
    logic [15:0] pc;
    logic        pc_valid, flush, halted;

    typedef struct packed {
        logic [15:0] pc;
        logic        valid;
        logic        flush;
        logic        halted;
    } exp_t;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    pc_next_unit dut (
        .clk(clk), .rst(rst), .branch(branch), .branch_valid(branch_valid),
        .branch_pc(branch_pc), .branch_offset(branch_offset), .jump(jump),
        .jump_target(jump_target), .stall(stall), .halt(halt),
        .pc(pc), .pc_valid(pc_valid), .flush(flush), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [15:0] p, input logic v, input logic f, input logic h);
        exp_t e;
        e.pc = p; e.valid = v; e.flush = f; e.halted = h;
        exp_q.push_back(e);
    endtask

    task automatic compare_now(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = exp_q.pop_front();
        compared++;
        assert (pc === e.pc) else begin
            mismatched++;
            $error("FAIL %s pc: got %h expected %h", tag, pc, e.pc);
        end
        compared++;
        assert (pc_valid === e.valid) else begin
            mismatched++;
            $error("FAIL %s pc_valid: got %b expected %b", tag, pc_valid, e.valid);
        end
        compared++;
        assert (flush === e.flush) else begin
            mismatched++;
            $error("FAIL %s flush: got %b expected %b", tag, flush, e.flush);
        end
        compared++;
        assert (halted === e.halted) else begin
            mismatched++;
            $error("FAIL %s halted: got %b expected %b", tag, halted, e.halted);
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        #1;
        compare_now(tag);
    endtask

    task automatic clear_inputs();
        branch = 0; branch_valid = 0; jump = 0; stall = 0; halt = 0;
        branch_pc = '0; branch_offset = '0; jump_target = '0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        #1;
        push(16'h0000, 0, 0, 0); compare_now("reset_async");
        push(16'h0000, 0, 0, 0); cycle("reset_hold1");
        push(16'h0000, 0, 0, 0); cycle("reset_hold2");
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            push(16'(i), 1, 0, 0); cycle("increment");
        end

        // backward branch: 0x10 + 1 - 4 = 0x0D
        branch_pc = 16'h0010; branch_offset = 8'hFC; branch_valid = 1; branch = 1;
        push(16'h000D, 1, 1, 0); cycle("bwd_target");
        clear_inputs();
        push(16'h000E, 1, 1, 0); cycle("bwd_flush2");
        push(16'h000F, 1, 0, 0); cycle("bwd_flush_end");

        // forward branch wrapping past 0xFFFF
        branch_pc = 16'hFFF0; branch_offset = 8'h7F; branch_valid = 1; branch = 1;
        push(16'h0070, 1, 1, 0); cycle("wrap_target");
        clear_inputs();
        push(16'h0071, 1, 1, 0); cycle("wrap_flush2");
        push(16'h0072, 1, 0, 0); cycle("wrap_flush_end");
        branch_pc = 16'hFFF0; branch_offset = 8'h7F; branch_valid = 1; branch = 0;
        push(16'h0073, 1, 0, 0); cycle("not_taken");
        clear_inputs();

        // branch + jump + stall together: branch wins
        branch_pc = 16'h0040; branch_offset = 8'h05; branch_valid = 1; branch = 1;
        jump = 1; jump_target = 16'h1234; stall = 1;
        push(16'h0046, 1, 1, 0); cycle("collide_branch_wins");
        clear_inputs();
        branch_pc = 16'h0100; branch_offset = 8'h00; branch_valid = 1; branch = 1;
        push(16'h0047, 1, 1, 0); cycle("branch_in_flush_ignored");
        clear_inputs();
        push(16'h0048, 1, 0, 0); cycle("collide_flush_end");

        // stall held across the flush window
        jump = 1; jump_target = 16'h0080;
        push(16'h0080, 1, 1, 0); cycle("jump_target");
        jump = 0; stall = 1;
        push(16'h0080, 1, 1, 0); cycle("stall_flush1");
        push(16'h0080, 1, 0, 0); cycle("stall_flush_end");
        push(16'h0080, 1, 0, 0); cycle("stall_run");
        stall = 0;
        push(16'h0081, 1, 0, 0); cycle("stall_release1");
        push(16'h0082, 1, 0, 0); cycle("stall_release2");

        // halt during flush at pc 0x20
        jump = 1; jump_target = 16'h001F;
        push(16'h001F, 1, 1, 0); cycle("jump_1f");
        jump = 0;
        push(16'h0020, 1, 1, 0); cycle("pc_20_flush");
        halt = 1;
        push(16'h0020, 0, 0, 1); cycle("halt_enter");
        halt = 0;
        for (int i = 0; i < 5; i++) begin
            branch_valid = (i % 2 == 0); branch = 1; branch_pc = 16'h0200;
            jump = (i == 3); jump_target = 16'h0300;
            push(16'h0020, 0, 0, 1); cycle("halt_frozen");
        end
        clear_inputs();

        // asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        push(16'h0000, 0, 0, 0); compare_now("async_reset");
        #2;
        rst = 1'b0;
        push(16'h0001, 1, 0, 0); cycle("post_reset_inc");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
